// File: rtl/data_mem_responder.sv
// MEM-stage data memory: combinational-read word RAM with byte lanes, a memory-mapped
// performance-counter bank, and sticky misalignment / access-fault flags.
module data_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        R_en,
    input  logic        W_en,
    input  logic [2:0]  RW_type,
    input  logic [31:0] ram_addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    input  logic        stat_beq,
    input  logic        stat_bne,
    input  logic        stat_blt,
    input  logic        stat_bge,
    input  logic        stat_bltu,
    input  logic        stat_bgeu,
    input  logic        stat_jal,
    input  logic        stat_jalr,
    input  logic        stat_PL_flush,
    output logic        misalign_err,
    output logic        access_fault
);

    localparam int unsigned Words = 2 ** DEPTH_LOG2;
    localparam int unsigned NumEv = 9;

    localparam logic [2:0] TypeB  = 3'b000;
    localparam logic [2:0] TypeH  = 3'b001;
    localparam logic [2:0] TypeW  = 3'b010;
    localparam logic [2:0] TypeBu = 3'b100;
    localparam logic [2:0] TypeHu = 3'b101;

    // Word offsets (byte offset >> 2) inside the counter bank.
    localparam logic [5:0] OffCycle  = 6'd0;
    localparam logic [5:0] OffCtrl   = 6'd10;
    localparam logic [5:0] OffStatus = 6'd11;

    logic [31:0] mem [Words];

    logic                  in_ram;
    logic                  in_mmio;
    logic                  unmapped;
    logic                  is_byte;
    logic                  is_half;
    logic                  is_word;
    logic                  is_unsigned;
    logic                  legal_load;
    logic                  legal_store;
    logic                  misaligned;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]           ram_word;
    logic [31:0]           ram_rdata;
    logic [31:0]           mmio_rdata;
    logic [4:0]            lane_shift;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic                  load_ram;
    logic                  load_mmio;
    logic                  store_ram;
    logic                  mmio_wr;
    logic                  ctrl_wr;
    logic                  status_wr;
    logic                  clr;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic                  misalign_set;
    logic                  fault_set;
    logic [NumEv-1:0]      ev_strobe;

    logic [31:0] cycle_q;
    logic [31:0] cycle_d;
    logic [31:0] ev_q [NumEv];
    logic [31:0] ev_d [NumEv];
    logic        freeze_q;
    logic        freeze_d;
    logic        misalign_q;
    logic        misalign_d;
    logic        fault_q;
    logic        fault_d;

    // Address decode; regions are mutually exclusive.
    assign word_idx = ram_addr[DEPTH_LOG2+1:2];
    assign in_ram   = (ram_addr[31:DEPTH_LOG2+2] == '0);
    assign in_mmio  = !in_ram && (ram_addr[31:8] == MMIO_BASE[31:8]);
    assign unmapped = !in_ram && !in_mmio;

    always_comb begin
        is_byte     = 1'b0;
        is_half     = 1'b0;
        is_word     = 1'b0;
        is_unsigned = 1'b0;
        case (RW_type)
            TypeB:  is_byte = 1'b1;
            TypeH:  is_half = 1'b1;
            TypeW:  is_word = 1'b1;
            TypeBu: begin
                is_byte     = 1'b1;
                is_unsigned = 1'b1;
            end
            TypeHu: begin
                is_half     = 1'b1;
                is_unsigned = 1'b1;
            end
            default: ;
        endcase
    end

    assign legal_load  = is_byte || is_half || is_word;
    assign legal_store = legal_load && !is_unsigned;
    assign misaligned  = (is_half && ram_addr[0]) || (is_word && (ram_addr[1:0] != 2'b00));

    assign load_ram  = legal_load && !misaligned && in_ram;
    assign load_mmio = is_word && !misaligned && in_mmio;
    assign store_ram = W_en && legal_store && !misaligned && in_ram;
    assign mmio_wr   = W_en && is_word && !misaligned && in_mmio;
    assign ctrl_wr   = mmio_wr && (ram_addr[7:2] == OffCtrl);
    assign status_wr = mmio_wr && (ram_addr[7:2] == OffStatus);
    assign clr       = ctrl_wr && store_data[0];

    // RAM read path and lane extraction.
    assign ram_word   = mem[word_idx];
    assign lane_shift = {ram_addr[1:0], 3'b000};
    assign byte_sel   = ram_word[lane_shift +: 8];
    assign half_sel   = ram_addr[1] ? ram_word[31:16] : ram_word[15:0];

    always_comb begin
        ram_rdata = '0;
        if (is_byte) begin
            ram_rdata = {{24{!is_unsigned && byte_sel[7]}}, byte_sel};
        end else if (is_half) begin
            ram_rdata = {{16{!is_unsigned && half_sel[15]}}, half_sel};
        end else if (is_word) begin
            ram_rdata = ram_word;
        end
    end

    always_comb begin
        mmio_rdata = '0;
        case (ram_addr[7:2])
            OffCycle:  mmio_rdata = cycle_q;
            OffCtrl:   mmio_rdata = {30'b0, freeze_q, 1'b0};
            OffStatus: mmio_rdata = {30'b0, fault_q, misalign_q};
            default: begin
                for (int i = 0; i < NumEv; i++) begin
                    if (ram_addr[7:2] == 6'(i + 1)) mmio_rdata = ev_q[i];
                end
            end
        endcase
    end

    always_comb begin
        load_data = '0;
        if (R_en) begin
            if (load_ram) begin
                load_data = ram_rdata;
            end else if (load_mmio) begin
                load_data = mmio_rdata;
            end
        end
    end

    // Store lane enables; data is replicated so each lane sees its slice.
    always_comb begin
        be    = 4'b0000;
        wdata = store_data;
        if (is_byte) begin
            be    = 4'b0001 << ram_addr[1:0];
            wdata = {4{store_data[7:0]}};
        end else if (is_half) begin
            be    = ram_addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{store_data[15:0]}};
        end else if (is_word) begin
            be    = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && store_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Error detection; load and store legality are judged separately.
    assign misalign_set = (R_en || W_en) && misaligned;
    assign fault_set    = (R_en && (!legal_load || unmapped || (in_mmio && !is_word)))
                       || (W_en && (!legal_store || unmapped || (in_mmio && !is_word)));

    assign ev_strobe = {stat_PL_flush, stat_jalr, stat_jal, stat_bgeu, stat_bltu,
                        stat_bge, stat_blt, stat_bne, stat_beq};

    assign cycle_d = clr ? 32'd0 : (freeze_q ? cycle_q : cycle_q + 32'd1);

    always_comb begin
        for (int i = 0; i < NumEv; i++) begin
            ev_d[i] = ev_q[i];
            if (clr) begin
                ev_d[i] = '0;
            end else if (!freeze_q && ev_strobe[i]) begin
                ev_d[i] = ev_q[i] + 32'd1;
            end
        end
        freeze_d   = ctrl_wr ? store_data[1] : freeze_q;
        // A new error outranks a same-cycle write-1-clear.
        misalign_d = misalign_set || (misalign_q && !(status_wr && store_data[0]));
        fault_d    = fault_set || (fault_q && !(status_wr && store_data[1]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q    <= '0;
            freeze_q   <= 1'b0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            for (int i = 0; i < NumEv; i++) ev_q[i] <= '0;
        end else begin
            cycle_q    <= cycle_d;
            freeze_q   <= freeze_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
            for (int i = 0; i < NumEv; i++) ev_q[i] <= ev_d[i];
        end
    end

    assign misalign_err = misalign_q;
    assign access_fault = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a vector table for single-cycle behaviour plus
// hand sequences for flag priority, counter wrap/freeze and mid-run reset.
module tb_data_mem_responder;

    localparam logic [2:0] TB  = 3'b000;
    localparam logic [2:0] TH  = 3'b001;
    localparam logic [2:0] TW  = 3'b010;
    localparam logic [2:0] TBU = 3'b100;
    localparam logic [2:0] THU = 3'b101;
    localparam logic [31:0] M  = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        R_en = 1'b0;
    logic        W_en = 1'b0;
    logic [2:0]  RW_type = 3'b0;
    logic [31:0] ram_addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] load_data;
    logic [8:0]  st = 9'h0;
    logic        misalign_err;
    logic        access_fault;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk           (clk),
        .rst           (rst),
        .R_en          (R_en),
        .W_en          (W_en),
        .RW_type       (RW_type),
        .ram_addr      (ram_addr),
        .store_data    (store_data),
        .load_data     (load_data),
        .stat_beq      (st[0]),
        .stat_bne      (st[1]),
        .stat_blt      (st[2]),
        .stat_bge      (st[3]),
        .stat_bltu     (st[4]),
        .stat_bgeu     (st[5]),
        .stat_jal      (st[6]),
        .stat_jalr     (st[7]),
        .stat_PL_flush (st[8]),
        .misalign_err  (misalign_err),
        .access_fault  (access_fault)
    );

    typedef struct {
        string       name;
        logic        r;
        logic        w;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic [8:0]  st;
        logic [31:0] ld;
        logic        mis;
        logic        flt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input string name, input logic r, input logic w,
                                input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                                input logic [8:0] s, input logic [31:0] ld, input logic mis,
                                input logic flt);
        vec_t v;
        v.name = name; v.r = r; v.w = w; v.t = t; v.a = a; v.d = d;
        v.st = s; v.ld = ld; v.mis = mis; v.flt = flt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive after the falling edge, leave 1 time unit for combinational settle.
    task automatic cyc(input logic rs, input logic r, input logic w, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] d, input logic [8:0] s);
        @(negedge clk);
        rst = rs; R_en = r; W_en = w; RW_type = t; ram_addr = a; store_data = d; st = s;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, TW, 32'h0, 32'h0, 9'h0);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b0, 1'b1, 1'b0, TW, a, 32'h0, 9'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b0, 1'b1, TW, a, d, 9'h0);
    endtask

    initial begin
        // Post-reset state, then RAM lanes and extension.
        vt.push_back(mk("rst_cycle",  1'b1, 1'b0, TW,  M,          32'h0, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("rst_status", 1'b1, 1'b0, TW,  M + 32'h2C, 32'h0, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("rst_beq",    1'b1, 1'b0, TW,  M + 32'h04, 32'h0, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("sw_10",  1'b0, 1'b1, TW,  32'h10, 32'h8081_82F3, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("lb_10",  1'b1, 1'b0, TB,  32'h10, 32'h0, 9'h0, 32'hFFFF_FFF3, 1'b0, 1'b0));
        vt.push_back(mk("lbu_10", 1'b1, 1'b0, TBU, 32'h10, 32'h0, 9'h0, 32'h0000_00F3, 1'b0, 1'b0));
        vt.push_back(mk("lh_12",  1'b1, 1'b0, TH,  32'h12, 32'h0, 9'h0, 32'hFFFF_8081, 1'b0, 1'b0));
        vt.push_back(mk("lhu_12", 1'b1, 1'b0, THU, 32'h12, 32'h0, 9'h0, 32'h0000_8081, 1'b0, 1'b0));
        // Byte merge.
        vt.push_back(mk("sw_20",  1'b0, 1'b1, TW,  32'h20, 32'h0, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("sb_21",  1'b0, 1'b1, TB,  32'h21, 32'h1234_56AB, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("sh_22",  1'b0, 1'b1, TH,  32'h22, 32'hABCD_1234, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("lw_20",  1'b1, 1'b0, TW,  32'h20, 32'h0, 9'h0, 32'h1234_AB00, 1'b0, 1'b0));
        // Misalignment, read-during-write, status W1C.
        vt.push_back(mk("sw55",   1'b0, 1'b1, TW,  32'h20, 32'h55, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("lw_21",  1'b1, 1'b0, TW,  32'h21, 32'h0, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("sh_23",  1'b0, 1'b1, TH,  32'h23, 32'hFFFF, 9'h0, 32'h0, 1'b1, 1'b0));
        vt.push_back(mk("lw55",   1'b1, 1'b0, TW,  32'h20, 32'h0, 9'h0, 32'h55, 1'b1, 1'b0));
        vt.push_back(mk("rw_20",  1'b1, 1'b1, TW,  32'h20, 32'h77, 9'h0, 32'h55, 1'b1, 1'b0));
        vt.push_back(mk("lw77",   1'b1, 1'b0, TW,  32'h20, 32'h0, 9'h0, 32'h77, 1'b1, 1'b0));
        vt.push_back(mk("clr_mis", 1'b0, 1'b1, TW, M + 32'h2C, 32'h1, 9'h0, 32'h0, 1'b1, 1'b0));
        vt.push_back(mk("stat0",  1'b1, 1'b0, TW,  M + 32'h2C, 32'h0, 9'h0, 32'h0, 1'b0, 1'b0));
        // Event counters and CLR priority.
        vt.push_back(mk("beq1",   1'b0, 1'b0, TW,  32'h0, 32'h0, 9'h001, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("beq2f",  1'b0, 1'b0, TW,  32'h0, 32'h0, 9'h101, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("beq3",   1'b0, 1'b0, TW,  32'h0, 32'h0, 9'h001, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("rd_beq", 1'b1, 1'b0, TW,  M + 32'h04, 32'h0, 9'h0, 32'd3, 1'b0, 1'b0));
        vt.push_back(mk("rd_fl",  1'b1, 1'b0, TW,  M + 32'h24, 32'h0, 9'h0, 32'd1, 1'b0, 1'b0));
        vt.push_back(mk("clr_beq", 1'b0, 1'b1, TW, M + 32'h28, 32'h1, 9'h001, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("rd_beq0", 1'b1, 1'b0, TW, M + 32'h04, 32'h0, 9'h0, 32'd0, 1'b0, 1'b0));
        vt.push_back(mk("rd_cyc1", 1'b1, 1'b0, TW, M,          32'h0, 9'h0, 32'd1, 1'b0, 1'b0));
        vt.push_back(mk("rd_ctrl", 1'b1, 1'b0, TW, M + 32'h28, 32'h0, 9'h0, 32'd0, 1'b0, 1'b0));
        // Unmapped, MMIO sub-word, illegal types.
        vt.push_back(mk("lw_unm", 1'b1, 1'b0, TW,  32'h8000_0000, 32'h0, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("clr_f1", 1'b0, 1'b1, TW,  M + 32'h2C, 32'h2, 9'h0, 32'h0, 1'b0, 1'b1));
        vt.push_back(mk("lh_mmio", 1'b1, 1'b0, TH, M,          32'h0, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("clr_f2", 1'b0, 1'b1, TW,  M + 32'h2C, 32'h2, 9'h0, 32'h0, 1'b0, 1'b1));
        vt.push_back(mk("sw_40",  1'b0, 1'b1, TW,  32'h40, 32'h1111_2222, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("st011",  1'b0, 1'b1, 3'b011, 32'h40, 32'h99, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("lw_40",  1'b1, 1'b0, TW,  32'h40, 32'h0, 9'h0, 32'h1111_2222, 1'b0, 1'b1));
        vt.push_back(mk("clr_f3", 1'b0, 1'b1, TW,  M + 32'h2C, 32'h2, 9'h0, 32'h0, 1'b0, 1'b1));
        vt.push_back(mk("ld110",  1'b1, 1'b0, 3'b110, 32'h40, 32'h0, 9'h0, 32'h0, 1'b0, 1'b0));
        vt.push_back(mk("idle_f", 1'b0, 1'b0, TW,  32'h0, 32'h0, 9'h0, 32'h0, 1'b0, 1'b1));

        cyc(1'b1, 1'b0, 1'b0, TW, 32'h0, 32'h0, 9'h0);
        cyc(1'b1, 1'b0, 1'b0, TW, 32'h0, 32'h0, 9'h0);

        for (int i = 0; i < vt.size(); i++) begin
            cyc(1'b0, vt[i].r, vt[i].w, vt[i].t, vt[i].a, vt[i].d, vt[i].st);
            check({vt[i].name, ".ld"}, load_data, vt[i].ld);
            check({vt[i].name, ".mis"}, {31'b0, misalign_err}, {31'b0, vt[i].mis});
            check({vt[i].name, ".flt"}, {31'b0, access_fault}, {31'b0, vt[i].flt});
        end

        // A fault raised in the same cycle as its write-1-clear must survive.
        wr(M + 32'h2C, 32'h2);
        force dut.fault_set = 1'b1;
        @(posedge clk);
        #1 release dut.fault_set;
        idle();
        check("set_beats_clr", {31'b0, access_fault}, 32'h1);
        wr(M + 32'h2C, 32'h3);
        idle();
        check("w1c_fault", {31'b0, access_fault}, 32'h0);

        // Cycle counter wrap, then FREEZE hold and release.
        idle();
        force dut.cycle_d = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 release dut.cycle_d;
        rd(M);
        check("cyc_max", load_data, 32'hFFFF_FFFF);
        rd(M);
        check("cyc_wrap", load_data, 32'h0);
        wr(M + 32'h28, 32'h2);
        rd(M);
        check("frz_a", load_data, 32'd2);
        rd(M + 32'h28);
        check("ctrl_frz", load_data, 32'h2);
        rd(M);
        check("frz_b", load_data, 32'd2);
        wr(M + 32'h28, 32'h0);
        rd(M);
        check("unfrz_a", load_data, 32'd2);
        rd(M);
        check("unfrz_b", load_data, 32'd3);

        // Reset mid-run drops the same-cycle store and clears counters, CTRL and flags.
        wr(32'h44, 32'hCAFE_F00D);
        wr(M + 32'h28, 32'h2);
        cyc(1'b0, 1'b1, 1'b0, TW, 32'h8000_0000, 32'h0, 9'h001);
        cyc(1'b0, 1'b1, 1'b0, TW, 32'h22, 32'h0, 9'h001);
        cyc(1'b1, 1'b0, 1'b1, TW, 32'h44, 32'hDEAD_BEEF, 9'h001);
        check("pre_rst_mis", {31'b0, misalign_err}, 32'h1);
        check("pre_rst_flt", {31'b0, access_fault}, 32'h1);
        rd(M);
        check("rst_cyc", load_data, 32'h0);
        check("rst_mis", {31'b0, misalign_err}, 32'h0);
        check("rst_flt", {31'b0, access_fault}, 32'h0);
        rd(M + 32'h04);
        check("rst_beq2", load_data, 32'h0);
        rd(32'h44);
        check("rst_drop_st", load_data, 32'hCAFE_F00D);
        rd(M + 32'h2C);
        check("rst_stat", load_data, 32'h0);
        rd(M + 32'h28);
        check("rst_ctrl", load_data, 32'h0);
        rd(M);
        check("rst_cyc_run", load_data, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
